// File: rtl/map_serial_loader_pkg.sv
// Shared serial map format constants, used by the editor dump and by the loader.
package map_serial_loader_pkg;

    localparam int unsigned MAP_COLS = 40;
    localparam int unsigned MAP_ROWS = 30;
    localparam int unsigned COORD_W  = 6;
    localparam logic [7:0]  SER_EOL  = 8'd13;

    typedef enum logic [1:0] {
        StIdle,
        StWaitByte,
        StWrite,
        StDone
    } loader_state_e;

endpackage

// File: rtl/map_serial_loader_byte_skid.sv
// One-entry byte buffer between the UART receiver and the loader FSM.
module map_serial_loader_byte_skid (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       rd,
    output logic       valid,
    output logic [7:0] rdata,
    output logic       ovf
);

    // A byte arriving in the same cycle the entry is consumed refills it.
    assign ovf = wr && valid && !rd && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            rdata <= 8'd0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr && (!valid || rd)) begin
            valid <= 1'b1;
            rdata <= wdata;
        end else if (rd) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/map_serial_loader.sv
// Loads a row-by-row serial map dump (EOL-terminated rows) into the game-map RAM.
module map_serial_loader
    import map_serial_loader_pkg::*;
#(
    parameter int unsigned COLS = MAP_COLS,
    parameter int unsigned ROWS = MAP_ROWS,
    parameter logic [7:0]  EOL  = SER_EOL
) (
    input  logic               px_clk,
    input  logic               rst,
    input  logic               load,
    input  logic               abort,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               map_busy,
    output logic               update,
    output logic [COORD_W-1:0] posx,
    output logic [COORD_W-1:0] posy,
    output logic [7:0]         sprite,
    output logic               loading,
    output logic               done,
    output logic               fmt_err
);

    localparam logic [COORD_W-1:0] COLS_C = COORD_W'(COLS);
    localparam logic [COORD_W-1:0] ROWS_C = COORD_W'(ROWS);

    loader_state_e      state;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] row_nxt;
    logic               buf_valid;
    logic [7:0]         buf_data;
    logic               buf_ovf;
    logic               buf_rd;
    logic               buf_wr;
    logic               buf_flush;

    assign row_nxt   = row + 1'b1;
    assign buf_rd    = (state == StWaitByte) && buf_valid;
    assign buf_wr    = rx_valid && (state != StIdle);
    assign buf_flush = load || abort;

    map_serial_loader_byte_skid u_byte_skid (
        .clk   (px_clk),
        .rst   (rst),
        .flush (buf_flush),
        .wr    (buf_wr),
        .wdata (rx_data),
        .rd    (buf_rd),
        .valid (buf_valid),
        .rdata (buf_data),
        .ovf   (buf_ovf)
    );

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            col     <= '0;
            row     <= '0;
            update  <= 1'b0;
            posx    <= '0;
            posy    <= '0;
            sprite  <= 8'd0;
            loading <= 1'b0;
            done    <= 1'b0;
            fmt_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != StIdle)) begin
                state   <= StIdle;
                update  <= 1'b0;
                loading <= 1'b0;
            end else if (load && !abort) begin
                state   <= StWaitByte;
                col     <= '0;
                row     <= '0;
                update  <= 1'b0;
                loading <= 1'b1;
                fmt_err <= 1'b0;
            end else begin
                if (buf_ovf) begin
                    fmt_err <= 1'b1;
                end
                unique case (state)
                    StIdle: ;
                    StWaitByte: begin
                        if (buf_valid) begin
                            if (buf_data == EOL) begin
                                col <= '0;
                                row <= row_nxt;
                                if (row_nxt == ROWS_C) begin
                                    state   <= StDone;
                                    done    <= 1'b1;
                                    loading <= 1'b0;
                                end
                            end else if (col < COLS_C) begin
                                posx   <= col;
                                posy   <= row;
                                sprite <= buf_data;
                                update <= 1'b1;
                                state  <= StWrite;
                            end else begin
                                // Row overrun: byte dropped, row stays open until EOL.
                                fmt_err <= 1'b1;
                            end
                        end
                    end
                    StWrite: begin
                        if (!map_busy) begin
                            update <= 1'b0;
                            col    <= col + 1'b1;
                            state  <= StWaitByte;
                        end
                    end
                    StDone:  state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
